led_scan_ctrl: RTL and testbench

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_scan_ctrl.sv | 114 +++++++++++
 tb/tb_led_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - four-digit multiplexed LED scan controller with frame-aligned data update
// Optional leading-zero blanking: define SCAN_LZB_EN.
module led_scan_ctrl #(
    parameter int SLOT_CYC = 1000,
    parameter int DEAD_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic [3:0]  char,
    output logic [3:0]  anode,
    output logic [1:0]  digit_idx,
    output logic        frame_done,
    output logic        pending
);

    localparam int CW = $clog2(SLOT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(DEAD_CYC);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    char_q, char_d;
    logic          wrap;
    logic          boundary;

    function automatic logic [3:0] digit_code(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] nib;
        logic       blank;
        case (i)
            2'd0:    nib = v[3:0];
            2'd1:    nib = v[7:4];
            2'd2:    nib = v[11:8];
            default: nib = v[15:12];
        endcase
`ifdef SCAN_LZB_EN
        // A digit is blanked only if it and every digit above it are zero.
        blank = ((i == 2'd3) && (v[15:12] == 4'h0)) ||
                ((i == 2'd2) && (v[15:8]  == 8'h00)) ||
                ((i == 2'd1) && (v[15:4]  == 12'h000));
`else
        blank = 1'b0;
`endif
        return blank ? 4'b1111 : nib;
    endfunction

    // Registered outputs are computed from next-state so they line up with cnt/idx.
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        boundary  = wrap && (idx_q == 2'd3);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        disp_d    = disp_q;
        shadow_d  = load ? data_in : shadow_q;
        pending_d = pending_q;
        if (boundary) begin
            if (load) begin
                disp_d = data_in;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
        state_d      = (cnt_d < CNT_ON) ? ST_DEAD : ST_ON;
        anode_d      = (state_d == ST_ON) ? ~(4'b0001 << idx_d) : 4'b1111;
        char_d       = digit_code(disp_d, idx_d);
        frame_done_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= ST_DEAD;
            disp_q       <= 16'hBBBB;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            anode_q      <= 4'b1111;
            char_q       <= 4'b1011;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            anode_q      <= (state_d == ST_ON) ? anode_d : 4'b1111;
            char_q       <= char_d;
        end
    end

    assign char       = char_q;
    assign anode      = (state_q == ST_ON) ? anode_q : 4'b1111;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - scoreboard bench for led_scan_ctrl against a time-based reference model
module tb_led_scan_ctrl;

    localparam int SLOT  = 10;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  char;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        pending;

    led_scan_ctrl #(.SLOT_CYC(SLOT), .DEAD_CYC(DEAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .char       (char),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] ch;
        logic [1:0] idx;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: cycles since reset release, shown value, and queued value.
    int          t = 0;
    logic [15:0] disp = 16'hBBBB;
    logic        pv = 1'b0;
    logic [15:0] pval = 16'h0000;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    function automatic logic [3:0] model_char(input logic [15:0] v, input int i);
        logic [15:0] upper;
        upper = v >> (4 * i);
`ifdef SCAN_LZB_EN
        if (i >= 1 && upper == 16'h0000) return 4'b1111;
`endif
        return upper[3:0];
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] d);
        exp_t e;
        int   cnt;
        int   idx;
        reset   = r;
        load    = l;
        data_in = d;
        @(posedge clk);
        #1;
        if (!r) begin
            t    = 0;
            disp = 16'hBBBB;
            pv   = 1'b0;
        end else begin
            if (t % FRAME == FRAME - 1) begin
                if (l) disp = d;
                else if (pv) disp = pval;
                pv = 1'b0;
            end else if (l) begin
                pv   = 1'b1;
                pval = d;
            end
            t++;
        end
        cnt     = t % SLOT;
        idx     = (t / SLOT) % 4;
        e.idx   = 2'(idx);
        e.fd    = (t % FRAME == FRAME - 1);
        e.pend  = pv;
        e.anode = (cnt < DEAD) ? 4'b1111 : ~(4'b0001 << idx);
        e.ch    = model_char(disp, idx);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom));
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) step(1'b1, 1'b0, 16'($urandom));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("anode", anode, e.anode);
            chk("char", char, e.ch);
            chk("digit_idx", digit_idx, e.idx);
            chk("frame_done", frame_done, e.fd);
            chk("pending", pending, e.pend);
            if (anode != 4'b1111 && !$onehot(~anode)) begin
                n_checks++;
                n_fail++;
                $display("FAIL anode_onehot at %0t: got %b expected at most one low bit", $time, anode);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0);
        idle(45);

        idle_until(15);
        step(1'b1, 1'b1, 16'h1234);
        idle(FRAME + 5);

        idle_until(5);
        step(1'b1, 1'b1, 16'h1111);
        idle(1);
        step(1'b1, 1'b1, 16'h5678);
        idle(FRAME + 5);

        idle_until(FRAME - 1);
        step(1'b1, 1'b1, 16'h9A0C);
        idle(FRAME);

        idle_until(3);
        step(1'b1, 1'b1, 16'h0070);
        idle(2 * FRAME);

        idle_until(25);
        step(1'b1, 1'b1, 16'hCDEF);
        idle(3);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            logic r;
            logic l;
            r = ($urandom_range(0, 299) != 0);
            l = ($urandom_range(0, 11) == 0);
            step(r, l, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom));
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
